// File: rtl/conv_requant_relu.sv
// conv_requant_relu: requantisation stage behind the 3x3 convolution core.
// First a bias list (one signed value per filter) is loaded. After that, every
// accumulator beat has its filter's bias added, goes through ReLU, is rounded,
// right-shifted and saturated to unsigned activations. Two registered stages
// separate the accumulator stream from the activation stream, and the frame-end
// marker (tlast) travels with its beat.
module conv_requant_relu #(
    parameter int IMG_HEIGHT = 5,
    parameter int IMG_WIDTH  = 4,
    parameter int FILTERS    = 8,
    parameter int LANES      = 2,
    parameter int ACC_WIDTH  = 16,
    parameter int WORD_WIDTH = 8,
    parameter int SHIFT      = 4
) (
    input  logic                            i_aclk,
    input  logic                            i_aresetn,
    input  logic                            i_bias_tvalid,
    output logic                            o_bias_tready,
    input  logic [ACC_WIDTH-1:0]            i_bias_tdata,
    input  logic                            i_acc_tvalid,
    output logic                            o_acc_tready,
    input  logic [LANES*ACC_WIDTH-1:0]      i_acc_tdata,
    input  logic                            i_out_tready,
    output logic                            o_out_tvalid,
    output logic [LANES*WORD_WIDTH-1:0]     o_out_tdata,
    output logic                            o_out_tlast
);

    localparam int NPIX  = IMG_HEIGHT * IMG_WIDTH;
    localparam int SUM_W = ACC_WIDTH + 1;   // acc + bias never overflows here
    localparam int RND_W = ACC_WIDTH + 2;   // adding the rounding offset never overflows here
    localparam int FW    = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [FW-1:0]    BIAS_LAST = FW'(FILTERS - 1);
    localparam logic [FW-1:0]    FIDX_LAST = FW'(FILTERS - LANES);
    localparam logic [PW-1:0]    PIX_LAST  = PW'(NPIX - 1);
    localparam logic [RND_W-1:0] SAT_MAX   = RND_W'((1 << WORD_WIDTH) - 1);

    typedef enum logic {
        LOAD_BIAS = 1'b0,
        RUN       = 1'b1
    } state_e;

    state_e                          state_q;
    logic [FW-1:0]                   bias_idx_q;
    logic [FW-1:0]                   fidx_q;
    logic [PW-1:0]                   pix_q;
    logic signed [ACC_WIDTH-1:0]     bias_mem [FILTERS];

    logic                            s1_valid_q;
    logic                            s1_last_q;
    logic [LANES-1:0][SUM_W-1:0]     s1_sum_q;
    logic [LANES-1:0][SUM_W-1:0]     s1_sum_d;

    logic                            out_valid_q;
    logic                            out_last_q;
    logic [LANES-1:0][WORD_WIDTH-1:0] out_data_q;
    logic [LANES-1:0][WORD_WIDTH-1:0] out_data_d;

    logic bias_fire;
    logic acc_fire;
    logic s2_adv;
    logic s1_ready;
    logic beat_last;

    // The output register can take a new beat when it is empty or being drained.
    // S1 can take a beat when it is empty or is moving into S2 this cycle.
    assign s2_adv        = !out_valid_q || i_out_tready;
    assign s1_ready      = !s1_valid_q || s2_adv;
    assign o_bias_tready = (state_q == LOAD_BIAS);
    assign o_acc_tready  = (state_q == RUN) && s1_ready;
    assign bias_fire     = i_bias_tvalid && o_bias_tready;
    assign acc_fire      = i_acc_tvalid && o_acc_tready;
    assign beat_last     = (fidx_q == FIDX_LAST) && (pix_q == PIX_LAST);

    assign o_out_tvalid  = out_valid_q;
    assign o_out_tdata   = out_data_q;
    assign o_out_tlast   = out_last_q;

    // Per-lane datapath: bias add and ReLU feed S1; round, shift and saturate feed S2.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] acc_lane;
        logic signed [ACC_WIDTH-1:0] bias_lane;
        logic signed [SUM_W-1:0]     sum;
        logic [RND_W-1:0]            rnd;

        assign acc_lane    = i_acc_tdata[k*ACC_WIDTH +: ACC_WIDTH];
        assign bias_lane   = bias_mem[fidx_q + FW'(k)];
        assign sum         = {acc_lane[ACC_WIDTH-1], acc_lane} + {bias_lane[ACC_WIDTH-1], bias_lane};
        assign s1_sum_d[k] = sum[SUM_W-1] ? '0 : sum;

        if (SHIFT > 0) begin : g_round
            assign rnd = ({1'b0, s1_sum_q[k]} + (RND_W'(1) << (SHIFT - 1))) >> SHIFT;
        end else begin : g_pass
            assign rnd = {1'b0, s1_sum_q[k]};
        end

        assign out_data_d[k] = (rnd > SAT_MAX) ? '1 : rnd[WORD_WIDTH-1:0];
    end

    // Bias table write. It is only read in RUN, and RUN is reached only after a full reload.
    // NOTE: storage arrays get no reset branch; after reset, validity comes from the
    // control state (LOAD_BIAS), not from clearing the contents.
    always_ff @(posedge i_aclk) begin
        if (bias_fire) begin
            bias_mem[bias_idx_q] <= i_bias_tdata;
        end
    end

    // Control: bias-load sequencing, then filter-index and pixel counting on accepted beats.
    // NOTE: every clocked block uses non-blocking assignments, so all registers update
    // together from the values they held before the edge.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q    <= LOAD_BIAS;
            bias_idx_q <= '0;
            fidx_q     <= '0;
            pix_q      <= '0;
        end else begin
            if (bias_fire) begin
                bias_idx_q <= bias_idx_q + FW'(1);
                if (bias_idx_q == BIAS_LAST) begin
                    state_q <= RUN;
                end
            end
            if (acc_fire) begin
                if (fidx_q == FIDX_LAST) begin
                    fidx_q <= '0;
                    pix_q  <= (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);
                end else begin
                    fidx_q <= fidx_q + FW'(LANES);
                end
            end
        end
    end

    // Two-stage pipeline with valid bits. An output register that is stalled keeps its contents.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= acc_fire;
                if (acc_fire) begin
                    s1_sum_q  <= s1_sum_d;
                    s1_last_q <= beat_last;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                    out_last_q <= s1_last_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_requant_relu.sv
// Scoreboard bench for conv_requant_relu. The driver pushes the expected activation
// beat for every accepted accumulator beat. Expected beats come from an arithmetic
// model indexed by the running beat number. A separate monitor pops and compares
// every delivered beat, and also checks stall stability and the input ready.
module tb_conv_requant_relu;

    localparam int IMG_HEIGHT = 5;
    localparam int IMG_WIDTH  = 4;
    localparam int FILTERS    = 8;
    localparam int LANES      = 2;
    localparam int ACC_WIDTH  = 16;
    localparam int WORD_WIDTH = 8;
    localparam int SHIFT      = 4;
    localparam int BPP        = FILTERS / LANES;               // beats per pixel
    localparam int BPF        = IMG_HEIGHT * IMG_WIDTH * BPP;  // beats per frame
    localparam int AW         = LANES * ACC_WIDTH;
    localparam int OW         = LANES * WORD_WIDTH;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bias_tvalid = 1'b0;
    logic          bias_tready;
    logic [ACC_WIDTH-1:0] bias_tdata = '0;
    logic          acc_tvalid = 1'b0;
    logic          acc_tready;
    logic [AW-1:0] acc_tdata = '0;
    logic          out_tready = 1'b1;
    logic          out_tvalid;
    logic [OW-1:0] out_tdata;
    logic          out_tlast;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            beat_n = 0;
    int            tlast_seen = 0;
    bit            run_phase = 1'b0;
    bit            always_ready = 1'b1;
    int            bias_m [FILTERS];
    logic [AW-1:0] stim [2*BPF];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_requant_relu #(
        .IMG_HEIGHT(IMG_HEIGHT), .IMG_WIDTH(IMG_WIDTH), .FILTERS(FILTERS), .LANES(LANES),
        .ACC_WIDTH(ACC_WIDTH), .WORD_WIDTH(WORD_WIDTH), .SHIFT(SHIFT)
    ) dut (
        .i_aclk        (clk),
        .i_aresetn     (rst_n),
        .i_bias_tvalid (bias_tvalid),
        .o_bias_tready (bias_tready),
        .i_bias_tdata  (bias_tdata),
        .i_acc_tvalid  (acc_tvalid),
        .o_acc_tready  (acc_tready),
        .i_acc_tdata   (acc_tdata),
        .i_out_tready  (out_tready),
        .o_out_tvalid  (out_tvalid),
        .o_out_tdata   (out_tdata),
        .o_out_tlast   (out_tlast)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: beat n of the stream belongs to filters base..base+LANES-1 of pixel n/BPP.
    function automatic logic [OW-1:0] model_data(input logic [AW-1:0] acc, input int n);
        logic [OW-1:0] res;
        int base, a, s, r;
        base = (n % BPP) * LANES;
        res  = '0;
        for (int k = 0; k < LANES; k++) begin
            a = int'($signed(acc[k*ACC_WIDTH +: ACC_WIDTH]));
            s = a + bias_m[base + k];
            if (s < 0) s = 0;
            r = (SHIFT > 0) ? (s + (1 << (SHIFT - 1))) / (1 << SHIFT) : s;
            if (r > (1 << WORD_WIDTH) - 1) r = (1 << WORD_WIDTH) - 1;
            res[k*WORD_WIDTH +: WORD_WIDTH] = r[WORD_WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] rand_acc();
        logic [AW-1:0]        v;
        logic [ACC_WIDTH-1:0] l;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 3))
                0:       l = ACC_WIDTH'($urandom);
                1:       l = -ACC_WIDTH'($urandom_range(0, 300));
                2:       l = ACC_WIDTH'($urandom_range(0, 5000));
                default: l = ACC_WIDTH'($urandom_range(4060, 4110));
            endcase
            v[k*ACC_WIDTH +: ACC_WIDTH] = l;
        end
        return v;
    endfunction

    // Monitor: runs at every negedge, when all inputs and outputs have settled.
    initial begin : monitor
        bit            stalled_prev;
        logic [OW-1:0] held_data;
        logic          held_last;
        exp_t          e;
        stalled_prev = 1'b0;
        held_data    = '0;
        held_last    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && run_phase) begin
                // Beats accepted but not yet delivered sit in S1/S2. Two of them means both are full.
                if (sb.size() > 2) begin
                    errors++;
                    $display("FAIL occupancy: %0d beats in flight, at most 2 allowed", sb.size());
                end
                check("acc_tready_vs_occupancy", acc_tready, (sb.size() < 2) || out_tready);
                if (stalled_prev) begin
                    check("stall_hold_valid", out_tvalid, 1'b1);
                    check("stall_hold_data", out_tdata, held_data);
                    check("stall_hold_last", out_tlast, held_last);
                end
                if (out_tvalid && out_tready) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h with no beat pending", out_tdata);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_tdata, e.data);
                        check("out_last", out_tlast, e.last);
                        if (always_ready) check("latency", 64'(cyc - e.cyc), 64'd2);
                        if (out_tlast) tlast_seen++;
                    end
                end
                stalled_prev = out_tvalid && !out_tready;
                held_data    = out_tdata;
                held_last    = out_tlast;
            end else begin
                stalled_prev = 1'b0;
            end
            @(posedge clk);
            #1;
            out_tready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [AW-1:0] acc);
        exp_t e;
        bit   done;
        done       = 1'b0;
        acc_tvalid = 1'b1;
        acc_tdata  = acc;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (acc_tready) begin
                e.data = model_data(acc, beat_n);
                e.last = ((beat_n % BPF) == BPF - 1);
                e.cyc  = cyc;
                sb.push_back(e);
                beat_n++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: o_acc_tready stayed 0 for 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        acc_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        acc_tvalid = 1'b0;
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run_phase   = 1'b0;
        acc_tvalid  = 1'b0;
        bias_tvalid = 1'b0;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        beat_n     = 0;
        tlast_seen = 0;
        rst_n      = 1'b1;
        @(negedge clk);
        check("rst_bias_tready", bias_tready, 1'b1);
        check("rst_acc_tready", acc_tready, 1'b0);
        check("rst_out_tvalid", out_tvalid, 1'b0);
        check("rst_out_tlast", out_tlast, 1'b0);
        check("rst_out_tdata", out_tdata, '0);
        @(posedge clk);
        #1;
    endtask

    // Loads biases (scaled by step: filter i gets i*step). Afterwards bias_tvalid stays high
    // with junk values, which the design must ignore in RUN.
    task automatic load_bias(input int step);
        always_ready = 1'b1;
        out_tready   = 1'b1;
        for (int i = 0; i < FILTERS; i++) begin
            bias_tvalid = 1'b1;
            bias_tdata  = ACC_WIDTH'(i * step);
            bias_m[i]   = i * step;
            @(negedge clk);
            check("load_bias_tready", bias_tready, 1'b1);
            check("load_acc_tready", acc_tready, 1'b0);
            @(posedge clk);
            #1;
        end
        bias_tdata = 16'h7FFF;
        @(negedge clk);
        check("run_bias_tready", bias_tready, 1'b0);
        check("run_acc_tready", acc_tready, 1'b1);
        @(posedge clk);
        #1;
        run_phase = 1'b1;
    endtask

    initial begin : main
        for (int i = 0; i < 2*BPF; i++) stim[i] = (i < 5) ? '0 : rand_acc();

        // Pass A: zero biases, arithmetic corners, then a reset with beats in flight.
        do_reset();
        load_bias(0);
        send({16'd40, -16'sd5});
        send({16'd8, 16'd7});
        send({16'd4095, 16'h7FFF});
        idle(3);
        for (int i = 0; i < 12; i++) begin
            send(rand_acc());
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        drain();
        always_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(rand_acc());

        // Pass B: biases i*16, two frames with the output always ready.
        do_reset();
        load_bias(16);
        bias_tdata = 16'h1234;
        for (int i = 0; i < 2*BPF; i++) begin
            send(stim[i]);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();
        check("tlast_count_ready", 64'(tlast_seen), 64'd2);

        // Pass C: same stream, random output backpressure; results must match pass B.
        do_reset();
        load_bias(16);
        always_ready = 1'b0;
        for (int i = 0; i < 2*BPF; i++) begin
            send(stim[i]);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();
        check("tlast_count_stall", 64'(tlast_seen), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
